// File: rtl/ntt_pkg.sv
// Shared NTT datapath constants and coefficient/product types.
package ntt_pkg;

    localparam int Q             = 8380417;
    localparam int K             = 23;
    localparam int Q_PRIME       = 8380415;
    localparam int N             = 256;
    localparam int PRODUCT_WIDTH = 64;

    typedef logic [31:0]              coeff_t;
    typedef logic [PRODUCT_WIDTH-1:0] product_t;

endpackage

// File: rtl/pipe_valid_stage.sv
// Generic valid/ready register stage; accepts whenever empty or draining.
module pipe_valid_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;

    // Combinational ready: the stage frees up in the same cycle it drains.
    assign in_ready  = !valid_reg || out_ready;
    assign out_valid = valid_reg;
    assign out_data  = data_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (in_ready) begin
            valid_reg <= in_valid;
            data_reg  <= in_data;
        end
    end

endmodule

// File: rtl/modmul_product_pipe.sv
// Two-stage back-pressured 32x32 multiplier tagging products with index/last.
// Optional sticky operand range check enabled by defining MODMUL_RANGE_CHECK_EN.
module modmul_product_pipe
    import ntt_pkg::*;
#(
    parameter int Q             = ntt_pkg::Q,
    parameter int N             = ntt_pkg::N,
    parameter int IDX_W         = $clog2(N),
    parameter int PRODUCT_WIDTH = ntt_pkg::PRODUCT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_a,
    input  logic [31:0]              in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PRODUCT_WIDTH-1:0] out_product,
    output logic [IDX_W-1:0]         out_index,
    output logic                     out_last,
    output logic                     err_range
);

    localparam int S1_W = 64 + IDX_W + 1;
    localparam int S2_W = PRODUCT_WIDTH + IDX_W + 1;

    if (Q < 2 || N < 2 || (N & (N - 1)) != 0 || IDX_W != $clog2(N) || PRODUCT_WIDTH < 64)
    begin : g_bad_config
        $error("modmul_product_pipe: unsupported parameter combination");
    end

    logic             in_xfer;
    logic [IDX_W-1:0] count_reg;
    logic             count_last;

    assign in_xfer    = in_valid && in_ready;
    assign count_last = (count_reg == IDX_W'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (in_xfer) begin
            count_reg <= count_last ? '0 : count_reg + IDX_W'(1);
        end
    end

    logic             s1_valid;
    logic             s2_adv;
    logic [S1_W-1:0]  s1_data;
    coeff_t           s1_a;
    coeff_t           s1_b;
    logic [IDX_W-1:0] s1_index;
    logic             s1_last;

    pipe_valid_stage #(.WIDTH(S1_W)) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({in_a, in_b, count_reg, count_last}),
        .out_valid (s1_valid),
        .out_ready (s2_adv),
        .out_data  (s1_data)
    );

    assign {s1_a, s1_b, s1_index, s1_last} = s1_data;

    // Full-width unsigned multiply; operands are zero-extended so nothing truncates.
    logic [63:0]     full_product;
    logic [S2_W-1:0] s2_data;

    assign full_product = {32'd0, s1_a} * {32'd0, s1_b};

    pipe_valid_stage #(.WIDTH(S2_W)) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s2_adv),
        .in_data   ({PRODUCT_WIDTH'(full_product), s1_index, s1_last}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_data)
    );

    assign {out_product, out_index, out_last} = s2_data;

`ifdef MODMUL_RANGE_CHECK_EN
    logic err_range_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_range_reg <= 1'b0;
        end else if (in_xfer && (in_a >= 32'(Q) || in_b >= 32'(Q))) begin
            err_range_reg <= 1'b1;
        end
    end

    assign err_range = err_range_reg;
`else
    assign err_range = 1'b0;
`endif

endmodule
